// File: rtl/nco_clock_gen_pkg.sv
// Shared constants, helper function and status type for the NCO clock-enable generator.
package nco_clock_gen_pkg;

    localparam int          ACC_W_DEF       = 32;
    localparam logic [31:0] DEFAULT_INC_DEF = 32'hF5C2_8F5C;
    localparam int          LOCK_CNT_DEF    = 4;
    localparam int          LOCK_W          = 8;

    // Channel-select width; a single channel still gets a one-bit select.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    typedef struct packed {
        logic pending;
        logic enabled;
        logic settled;
    } ch_status_t;

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator, shadow increment applied at a phase boundary, lock counter.
// Optional per-channel phase offset loaded on sync when NCO_PHASE_OFFSET_EN is defined.
module nco_channel
    import nco_clock_gen_pkg::*;
#(
    parameter int               ACC_W    = ACC_W_DEF,
    parameter logic [ACC_W-1:0] RST_INC  = '0,
    parameter int               LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic             sync,
`ifdef NCO_PHASE_OFFSET_EN
    input  logic             off_en,
    input  logic [ACC_W-1:0] off_val,
`endif
    output logic             ce,
    output logic             outclk,
    output ch_status_t       status
);

    typedef struct packed {
        logic [ACC_W-1:0]  acc;
        logic [ACC_W-1:0]  inc;
        logic [ACC_W-1:0]  shadow;
        logic              pending;
        logic [LOCK_W-1:0] lock_cnt;
        logic              wrap;
        logic              ce;
        logic              outclk;
    } ch_state_t;

    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CNT);
    localparam ch_state_t         RST_STATE = '{
        acc: '0, inc: RST_INC, shadow: '0, pending: 1'b0,
        lock_cnt: '0, wrap: 1'b0, ce: 1'b0, outclk: 1'b0
    };

    ch_state_t        st_reg;
    ch_state_t        st_next;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sync_acc;

`ifdef NCO_PHASE_OFFSET_EN
    logic [ACC_W-1:0] offset_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_reg <= '0;
        end else if (off_en) begin
            offset_reg <= off_val;
        end
    end

    assign sync_acc = offset_reg;
`else
    assign sync_acc = '0;
`endif

    assign sum = {1'b0, st_reg.acc} + {1'b0, st_reg.inc};

    always_comb begin
        st_next = st_reg;
        if (sync) begin
            // Restart the phase; a same-cycle write bypasses the shadow entirely.
            st_next.acc      = sync_acc;
            st_next.wrap     = 1'b0;
            st_next.ce       = 1'b0;
            st_next.outclk   = 1'b0;
            st_next.lock_cnt = '0;
            st_next.pending  = 1'b0;
            if (wr_en) begin
                st_next.inc = wr_inc;
            end else if (st_reg.pending) begin
                st_next.inc = st_reg.shadow;
            end
        end else if (st_reg.inc == '0) begin
            // Disabled: no boundary will ever come, so a pending value applies at once.
            st_next.acc    = '0;
            st_next.wrap   = 1'b0;
            st_next.ce     = 1'b0;
            st_next.outclk = 1'b0;
            if (st_reg.pending) begin
                st_next.inc      = st_reg.shadow;
                st_next.pending  = 1'b0;
                st_next.lock_cnt = '0;
            end else if (wr_en) begin
                st_next.shadow  = wr_inc;
                st_next.pending = 1'b1;
            end
        end else begin
            st_next.acc    = sum[ACC_W-1:0];
            st_next.wrap   = sum[ACC_W];
            st_next.ce     = st_reg.wrap;
            st_next.outclk = st_reg.acc[ACC_W-1];
            if (st_reg.pending && st_reg.wrap) begin
                st_next.inc      = st_reg.shadow;
                st_next.pending  = 1'b0;
                st_next.lock_cnt = '0;
            end else begin
                if (wr_en) begin
                    st_next.shadow  = wr_inc;
                    st_next.pending = 1'b1;
                end
                if (st_reg.wrap && (st_reg.lock_cnt != LOCK_MAX)) begin
                    st_next.lock_cnt = st_reg.lock_cnt + LOCK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg <= RST_STATE;
        end else begin
            st_reg <= st_next;
        end
    end

    assign ce             = st_reg.ce;
    assign outclk         = st_reg.outclk;
    assign status.pending = st_reg.pending;
    assign status.enabled = (st_reg.inc != '0);
    assign status.settled = (st_reg.lock_cnt == LOCK_MAX);

endmodule

// File: rtl/nco_clock_gen.sv
// Multi-channel numerically controlled clock-enable generator in the refclk domain.
// Define NCO_PHASE_OFFSET_EN to add per-channel phase offsets loaded by sync_req.
module nco_clock_gen
    import nco_clock_gen_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          ACC_W       = ACC_W_DEF,
    parameter logic [31:0] DEFAULT_INC = DEFAULT_INC_DEF,
    parameter int          LOCK_CNT    = LOCK_CNT_DEF
) (
    input  logic                        refclk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0] wr_ch,
    input  logic [ACC_W-1:0]            wr_inc,
    input  logic                        sync_req,
`ifdef NCO_PHASE_OFFSET_EN
    input  logic                        off_valid,
    input  logic [ch_idx_w(NUM_CH)-1:0] off_ch,
    input  logic [ACC_W-1:0]            off_val,
`endif
    output logic [NUM_CH-1:0]           ce,
    output logic [NUM_CH-1:0]           outclk,
    output logic                        locked
);

    localparam int               CH_W    = ch_idx_w(NUM_CH);
    localparam int               CH_SPAN = 1 << CH_W;
    localparam logic [ACC_W-1:0] RST_INC = ACC_W'(DEFAULT_INC);

    ch_status_t [NUM_CH-1:0] status;
    logic [CH_SPAN-1:0]      pending_span;
    logic [NUM_CH-1:0]       wr_en;
    logic [NUM_CH-1:0]       enabled;
    logic [NUM_CH-1:0]       settled;
    logic                    locked_reg;
    logic                    locked_next;
`ifdef NCO_PHASE_OFFSET_EN
    logic [NUM_CH-1:0]       off_en;
`endif

    // Unpopulated select codes read as never pending, so such writes are accepted and dropped.
    genvar gi;
    generate
        for (gi = 0; gi < CH_SPAN; gi++) begin : g_span
            if (gi < NUM_CH) begin : g_real
                assign pending_span[gi] = status[gi].pending;
            end else begin : g_void
                assign pending_span[gi] = 1'b0;
            end
        end
    endgenerate

    assign wr_ready = !pending_span[wr_ch];

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_en[gi] = wr_valid && wr_ready && (wr_ch == CH_W'(gi));
`ifdef NCO_PHASE_OFFSET_EN
            assign off_en[gi] = off_valid && (off_ch == CH_W'(gi));
`endif

            nco_channel #(
                .ACC_W    (ACC_W),
                .RST_INC  (RST_INC),
                .LOCK_CNT (LOCK_CNT)
            ) u_ch (
                .clk     (refclk),
                .rst_n   (rst_n),
                .wr_en   (wr_en[gi]),
                .wr_inc  (wr_inc),
                .sync    (sync_req),
`ifdef NCO_PHASE_OFFSET_EN
                .off_en  (off_en[gi]),
                .off_val (off_val),
`endif
                .ce      (ce[gi]),
                .outclk  (outclk[gi]),
                .status  (status[gi])
            );

            assign enabled[gi] = status[gi].enabled;
            assign settled[gi] = status[gi].settled;
        end
    endgenerate

    // Disabled channels are ignored; with none enabled there is nothing to be locked to.
    always_comb begin
        locked_next = (|enabled) && (&(settled | ~enabled));
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            locked_reg <= 1'b0;
        end else begin
            locked_reg <= locked_next;
        end
    end

    assign locked = locked_reg;

endmodule

// File: tb/tb_nco_clock_gen.sv
// Directed self-checking bench for nco_clock_gen (4 channels, 32-bit accumulator).
module tb_nco_clock_gen;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_ch;
    logic [31:0] wr_inc;
    logic        sync_req;
    logic [3:0]  ce;
    logic [3:0]  outclk;
    logic        locked;
`ifdef NCO_PHASE_OFFSET_EN
    logic        off_valid;
    logic [1:0]  off_ch;
    logic [31:0] off_val;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 refclk = ~refclk;

    nco_clock_gen #(
        .NUM_CH      (4),
        .ACC_W       (32),
        .DEFAULT_INC (32'hF5C2_8F5C),
        .LOCK_CNT    (4)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_ch     (wr_ch),
        .wr_inc    (wr_inc),
        .sync_req  (sync_req),
`ifdef NCO_PHASE_OFFSET_EN
        .off_valid (off_valid),
        .off_ch    (off_ch),
        .off_val   (off_val),
`endif
        .ce        (ce),
        .outclk    (outclk),
        .locked    (locked)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic write_inc(input logic [1:0] ch, input logic [31:0] val);
        wr_ch    = ch;
        wr_inc   = val;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        int          first_ce, lock_first, strobes, t4, lock_t, tog_ce, tog_clk, n;
        int          ce_cnt [4];
        int          first_k [4];
        logic        prev_ce, prev_clk, early, drop_lk, any_out;
        logic [19:0] vec20;
`ifdef NCO_PHASE_OFFSET_EN
        logic [15:0] vec0, vec1;
        off_valid = 1'b0;
        off_ch    = 2'd0;
        off_val   = 32'd0;
`endif
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_ch    = 2'd0;
        wr_inc   = 32'd0;
        sync_req = 1'b0;

        // Reset state and default-rate run
        repeat (3) step();
        check_eq("rst_ce",     64'(ce),       64'h0);
        check_eq("rst_outclk", 64'(outclk),   64'h0);
        check_eq("rst_locked", 64'(locked),   64'h0);
        check_eq("rst_ready",  64'(wr_ready), 64'h1);
        rst_n      = 1'b1;
        first_ce   = 0;
        lock_first = 0;
        for (int i = 0; i < 4; i++) ce_cnt[i] = 0;
        for (int t = 1; t <= 5000; t++) begin
            step();
            for (int i = 0; i < 4; i++) if (ce[i]) ce_cnt[i]++;
            if (ce[0] && first_ce == 0) first_ce = t;
            if (locked && lock_first == 0) lock_first = t;
        end
        check_eq("dflt_first_ce", 64'(first_ce),   64'd3);
        check_eq("dflt_lock_at",  64'(lock_first), 64'd7);
        check_eq("dflt_ce_cnt0",  64'(ce_cnt[0]),  64'd4799);
        check_eq("dflt_ce_cnt3",  64'(ce_cnt[3]),  64'd4799);
        check_eq("dflt_locked",   64'(locked),     64'h1);

        // Half-rate on ch1: blocked until its boundary, then toggles every cycle
        wr_ch = 2'd1;
        #1;
        check_eq("hr_ready_pre", 64'(wr_ready), 64'h1);
        write_inc(2'd1, 32'h8000_0000);
        check_eq("hr_ready_pend", 64'(wr_ready), 64'h0);
        early = 1'b0;
        n     = 0;
        do begin
            step();
            n++;
            if (!ce[1] && wr_ready) early = 1'b1;
        end while (!ce[1] && n < 20);
        check_eq("hr_ce_seen",     64'(ce[1]),    64'h1);
        check_eq("hr_ready_early", 64'(early),    64'h0);
        check_eq("hr_ready_after", 64'(wr_ready), 64'h1);
        strobes = 0;
        t4      = 0;
        lock_t  = 0;
        drop_lk = 1'b1;
        for (int t = 1; t <= 40 && lock_t == 0; t++) begin
            step();
            if (t == 1) drop_lk = locked;
            if (ce[1]) strobes++;
            if (strobes == 4 && t4 == 0) t4 = t;
            if (locked && lock_t == 0) lock_t = t;
        end
        check_eq("hr_lock_drop", 64'(drop_lk),     64'h0);
        check_eq("hr_relock",    64'(lock_t - t4), 64'd1);
        prev_ce  = ce[1];
        prev_clk = outclk[1];
        tog_ce   = 0;
        tog_clk  = 0;
        for (int t = 0; t < 8; t++) begin
            step();
            if (ce[1] != prev_ce) tog_ce++;
            if (outclk[1] != prev_clk) tog_clk++;
            prev_ce  = ce[1];
            prev_clk = outclk[1];
        end
        check_eq("hr_ce_toggle",  64'(tog_ce),  64'd8);
        check_eq("hr_clk_toggle", 64'(tog_clk), 64'd8);

        // Disable every channel, then revive ch2 at quarter rate
        for (int i = 0; i < 4; i++) write_inc(2'(i), 32'h0);
        repeat (12) step();
        any_out = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            if ((ce | outclk) != 4'h0) any_out = 1'b1;
        end
        check_eq("dis_outputs", 64'(any_out), 64'h0);
        check_eq("dis_locked",  64'(locked),  64'h0);
        write_inc(2'd2, 32'h4000_0000);
        check_eq("q_ready_pend", 64'(wr_ready), 64'h0);
        vec20  = '0;
        lock_t = 0;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (t == 1) check_eq("q_applied_next", 64'(wr_ready), 64'h1);
            vec20[t-1] = ce[2];
            if (locked && lock_t == 0) lock_t = t;
        end
        check_eq("q_ce_pattern", 64'(vec20),  64'h2_2220);
        check_eq("q_lock_at",    64'(lock_t), 64'd19);

        // Sync with a same-cycle write to ch3
        write_inc(2'd0, 32'h8000_0000);
        write_inc(2'd1, 32'h4000_0000);
        write_inc(2'd3, 32'h2000_0000);
        repeat (5) step();
        wr_ch    = 2'd3;
        wr_inc   = 32'h1000_0000;
        wr_valid = 1'b1;
        sync_req = 1'b1;
        #1;
        check_eq("sync_wr_ready", 64'(wr_ready), 64'h1);
        step();
        wr_valid = 1'b0;
        sync_req = 1'b0;
        check_eq("sync_ce_zero",  64'(ce),       64'h0);
        check_eq("sync_ch3_idle", 64'(wr_ready), 64'h1);
        for (int i = 0; i < 4; i++) first_k[i] = 0;
        drop_lk = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (t == 1) drop_lk = locked;
            for (int i = 0; i < 4; i++) if (ce[i] && first_k[i] == 0) first_k[i] = t;
        end
        check_eq("sync_lock_clr", 64'(drop_lk),    64'h0);
        check_eq("sync_first0",   64'(first_k[0]), 64'd3);
        check_eq("sync_first1",   64'(first_k[1]), 64'd5);
        check_eq("sync_first2",   64'(first_k[2]), 64'd5);
        check_eq("sync_first3",   64'(first_k[3]), 64'd17);

        // Asynchronous reset with a write pending
        repeat (200) step();
        check_eq("arst_pre_locked", 64'(locked), 64'h1);
        write_inc(2'd3, 32'h8000_0000);
        check_eq("arst_pending", 64'(wr_ready), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ce",     64'(ce),       64'h0);
        check_eq("arst_outclk", 64'(outclk),   64'h0);
        check_eq("arst_locked", 64'(locked),   64'h0);
        check_eq("arst_ready",  64'(wr_ready), 64'h1);
        step();
        rst_n    = 1'b1;
        first_ce = 0;
        strobes  = 0;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (ce[3]) strobes++;
            if (ce[3] && first_ce == 0) first_ce = t;
        end
        check_eq("arst_first_ce", 64'(first_ce), 64'd3);
        check_eq("arst_ce_cnt",   64'(strobes),  64'd6);
        check_eq("arst_no_pend",  64'(wr_ready), 64'h1);

`ifdef NCO_PHASE_OFFSET_EN
        // Quadrature via offset on ch1
        write_inc(2'd0, 32'h4000_0000);
        write_inc(2'd1, 32'h4000_0000);
        off_ch    = 2'd1;
        off_val   = 32'h4000_0000;
        off_valid = 1'b1;
        step();
        off_valid = 1'b0;
        sync_req  = 1'b1;
        step();
        sync_req = 1'b0;
        vec0 = '0;
        vec1 = '0;
        for (int t = 1; t <= 16; t++) begin
            step();
            vec0[t-1] = ce[0];
            vec1[t-1] = ce[1];
        end
        check_eq("off_ce0", 64'(vec0), 64'h1110);
        check_eq("off_ce1", 64'(vec1), 64'h8888);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
